// File: rtl/mem_arbiter_pkg.sv
// Shared types for mem_arbiter: FSM states, requester IDs, latency counter width, request payload.
package mem_arbiter_pkg;

    localparam int unsigned MEM_ARB_LAT_W = 3;
    localparam int unsigned MEM_ARB_DW    = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        MEM_ARB_IF = 1'b0,
        MEM_ARB_D  = 1'b1
    } arb_port_t;

    typedef struct packed {
        logic                  rw;
        logic [MEM_ARB_DW-1:0] addr;
        logic [MEM_ARB_DW-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise data has fixed priority.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic      if_req,
    input  logic      d_req,
`ifdef MEM_ARB_RR_EN
    input  arb_port_t last_gnt,
`endif
    output logic      pick_valid,
    output arb_port_t pick_id
);

    always_comb begin
        pick_valid = if_req | d_req;
        pick_id    = MEM_ARB_IF;
`ifdef MEM_ARB_RR_EN
        // On a tie, favour whichever port did not win last time
        if (if_req && d_req) begin
            pick_id = (last_gnt == MEM_ARB_IF) ? MEM_ARB_D : MEM_ARB_IF;
        end else if (d_req) begin
            pick_id = MEM_ARB_D;
        end
`else
        if (d_req) begin
            pick_id = MEM_ARB_D;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IF and MEM-stage requests onto one fixed-latency synchronous memory port.
// Optional round-robin tie-breaking is enabled by defining MEM_ARB_RR_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [31:0] mem_aout,
    output logic [31:0] mem_dout,
    input  logic [31:0] mem_din,
    output logic        busy
);

    arb_state_t               state_q, state_d;
    arb_port_t                owner_q, owner_d;
    mem_req_t                 req_q, req_d;
    logic [MEM_ARB_LAT_W-1:0] cnt_q, cnt_d;
    logic [31:0]              if_rdata_q, if_rdata_d;
    logic [31:0]              d_rdata_q, d_rdata_d;
    logic                     arb_en;
    logic                     grant;
    logic                     cnt_done;
    logic                     pick_valid;
    arb_port_t                pick_id;
`ifdef MEM_ARB_RR_EN
    arb_port_t                last_q, last_d;
`endif

    assign arb_en   = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign grant    = arb_en && pick_valid;
    assign cnt_done = (state_q == ST_WAIT) && (cnt_q == MEM_ARB_LAT_W'(1));

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
`ifdef MEM_ARB_RR_EN
        .last_gnt   (last_q),
`endif
        .pick_valid (pick_valid),
        .pick_id    (pick_id)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RESP: state_d = pick_valid ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:         state_d = ST_WAIT;
            ST_WAIT:          if (cnt_done) state_d = ST_RESP;
            default:          state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; grants are decoded combinationally so IDLE/RESP can grant with zero latency
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        mem_en    = 1'b0;
        mem_rw    = 1'b0;
        busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if_gnt    = pick_valid && (pick_id == MEM_ARB_IF);
                d_gnt     = pick_valid && (pick_id == MEM_ARB_D);
                if_rvalid = (state_q == ST_RESP) && (owner_q == MEM_ARB_IF);
                d_rvalid  = (state_q == ST_RESP) && (owner_q == MEM_ARB_D);
            end
            ST_ISSUE: begin
                mem_en = 1'b1;
                mem_rw = req_q.rw;
            end
            default: ;
        endcase
    end

    assign mem_aout = req_q.addr;
    assign mem_dout = req_q.wdata;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

    // Request capture, latency countdown and read-data capture
    always_comb begin
        owner_d    = owner_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_d     = last_q;
`endif
        if (grant) begin
            owner_d = pick_id;
`ifdef MEM_ARB_RR_EN
            last_d  = pick_id;
`endif
            if (pick_id == MEM_ARB_D) begin
                req_d = '{rw: d_rw, addr: d_addr, wdata: d_wdata};
            end else begin
                req_d = '{rw: 1'b0, addr: if_addr, wdata: 32'h0};
            end
        end
        if (state_q == ST_ISSUE) begin
            cnt_d = MEM_ARB_LAT_W'(LATENCY);
        end
        if (state_q == ST_WAIT) begin
            cnt_d = cnt_q - MEM_ARB_LAT_W'(1);
            // Writes complete without touching the load-data register
            if (cnt_done && !req_q.rw) begin
                if (owner_q == MEM_ARB_D) begin
                    d_rdata_d = mem_din;
                end else begin
                    if_rdata_d = mem_din;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q    <= MEM_ARB_IF;
            req_q      <= '0;
            cnt_q      <= '0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
`ifdef MEM_ARB_RR_EN
            last_q     <= MEM_ARB_IF;
`endif
        end else begin
            owner_q    <= owner_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard and a fixed-latency memory model.
// Tie-break expectations follow MEM_ARB_RR_EN when the macro is defined.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned LAT    = 3;
    localparam logic [31:0] POISON = 32'hBAD0_BAD0;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_rw;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_rw;
    logic [31:0] mem_aout, mem_dout, mem_din;
    logic        busy;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        last_d  = 1'b0;
    logic [31:0] exp_d_rdata  = 32'h0;
    logic [31:0] exp_if_rdata = 32'h0;
    logic [31:0] exp_aout, exp_dout;
    logic        exp_rw;
    logic [31:0] pipe [LAT];
    logic        w, w2;

    mem_arbiter #(.LATENCY(LAT)) dut (
        .clock    (clock),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_rw     (d_rw),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_rw   (mem_rw),
        .mem_aout (mem_aout),
        .mem_dout (mem_dout),
        .mem_din  (mem_din),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : ((a ^ 32'hC0DE_0000) + 32'h11);
    endfunction

    // Memory returns read data LAT cycles after the edge that samples mem_en
    always @(posedge clock) begin
        pipe[0] <= (mem_en && !mem_rw) ? rd(mem_aout) : POISON;
        for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign mem_din = pipe[LAT-1];

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    // Arbitration-cycle check: expected winner from driven requests, push expected response
    task automatic grant_step(output logic win_d);
        logic any;
        any = if_req | d_req;
`ifdef MEM_ARB_RR_EN
        win_d = d_req && (!if_req || !last_d);
`else
        win_d = d_req;
`endif
        check1("if_gnt", if_gnt, any && !win_d);
        check1("d_gnt", d_gnt, win_d);
        if (any) begin
            last_d = win_d;
            if (win_d) begin
                exp_rw   = d_rw;
                exp_aout = d_addr;
                exp_dout = d_wdata;
                if (!d_rw) exp_d_rdata = rd(d_addr);
                exp_q.push_back({1'b1, exp_d_rdata});
            end else begin
                exp_rw       = 1'b0;
                exp_aout     = if_addr;
                exp_dout     = 32'h0;
                exp_if_rdata = rd(if_addr);
                exp_q.push_back({1'b0, exp_if_rdata});
            end
        end
    endtask

    // ISSUE cycle then LAT WAIT cycles; the winner's request is retired after its grant
    task automatic do_txn(input logic win_d, input logic hold_if, input logic [31:0] nxt_if_addr);
        cyc();
        if (win_d) begin
            d_req = 1'b0;
        end else begin
            if_req  = hold_if;
            if_addr = nxt_if_addr;
        end
        mid();
        check1("issue_en", mem_en, 1'b1);
        check32("issue_aout", mem_aout, exp_aout);
        check1("issue_rw", mem_rw, exp_rw);
        check32("issue_dout", mem_dout, exp_dout);
        check1("issue_gnt", if_gnt | d_gnt, 1'b0);
        for (int i = 0; i < int'(LAT); i++) begin
            cyc();
            mid();
            check1("wait_en", mem_en, 1'b0);
            check1("wait_gnt", if_gnt | d_gnt, 1'b0);
            check1("wait_rvalid", if_rvalid | d_rvalid, 1'b0);
            check1("wait_busy", busy, 1'b1);
        end
    endtask

    task automatic resp_step(input logic win_d);
        check1("resp_if_rvalid", if_rvalid, !win_d);
        check1("resp_d_rvalid", d_rvalid, win_d);
        check1("resp_busy", busy, 1'b1);
    endtask

    // Handshake rules and response scoreboard
    always @(negedge clock) begin
        resp_t e;
        if (if_gnt || d_gnt) begin
            check1("gnt_onehot", if_gnt && d_gnt, 1'b0);
            check1("gnt_has_req", (if_gnt && !if_req) || (d_gnt && !d_req), 1'b0);
        end
        if (if_rvalid || d_rvalid) begin
            if (exp_q.size() == 0) begin
                check1("rvalid_unexpected", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check1("resp_port", d_rvalid, e.is_d);
                check1("resp_onehot", if_rvalid && d_rvalid, 1'b0);
                check32("resp_data", e.is_d ? d_rdata : if_rdata, e.data);
            end
        end
    end

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_rw = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        repeat (2) cyc();
        mid();
        check1("rst_busy", busy, 1'b0);
        check1("rst_mem_en", mem_en, 1'b0);
        check1("rst_mem_rw", mem_rw, 1'b0);
        check1("rst_gnt", if_gnt | d_gnt, 1'b0);
        check1("rst_rvalid", if_rvalid | d_rvalid, 1'b0);
        check32("rst_aout", mem_aout, 32'h0);
        check32("rst_dout", mem_dout, 32'h0);
        check32("rst_if_rdata", if_rdata, 32'h0);
        check32("rst_d_rdata", d_rdata, 32'h0);

        // Single fetch
        cyc(); reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        mid(); check1("fetch_idle_busy", busy, 1'b0); grant_step(w);
        do_txn(w, 1'b0, 32'h0);
        cyc(); mid(); resp_step(w);
        check32("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
        cyc(); mid();
        check1("fetch_done_busy", busy, 1'b0);
        check1("fetch_done_rvalid", if_rvalid | d_rvalid, 1'b0);

        // Data read, then a store that must leave d_rdata alone
        cyc(); d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h300; d_wdata = 32'h0;
        mid(); grant_step(w);
        do_txn(w, 1'b0, 32'h0);
        cyc(); d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678;
        mid(); resp_step(w); grant_step(w);
        do_txn(w, 1'b0, 32'h0);
        cyc(); d_rw = 1'b0; d_wdata = 32'h0;
        mid(); resp_step(w);
        check32("store_keeps_rdata", d_rdata, rd(32'h300));

        // Simultaneous requests, winner re-requests at the next arbitration point
        cyc(); d_req = 1'b1; d_addr = 32'h400; if_req = 1'b1; if_addr = 32'h500;
        mid(); grant_step(w);
        do_txn(w, 1'b0, 32'h500);
        cyc();
        if (w) begin d_req = 1'b1; d_addr = 32'h404; end
        else begin if_req = 1'b1; if_addr = 32'h504; end
        mid(); resp_step(w); grant_step(w2);
        do_txn(w2, 1'b0, if_addr);
        cyc(); mid(); resp_step(w2); grant_step(w);
        do_txn(w, 1'b0, 32'h0);
        cyc(); mid(); resp_step(w); grant_step(w2);

        // Back-to-back fetches with if_req held
        cyc(); if_req = 1'b1; if_addr = 32'h1000;
        mid(); grant_step(w);
        for (int k = 1; k <= 3; k++) begin
            do_txn(w, 1'b1, 32'h1000 + 32'(4 * k));
            cyc(); mid(); resp_step(w); grant_step(w);
        end
        do_txn(w, 1'b0, 32'h0);
        cyc(); mid(); resp_step(w);

        // Reset while waiting on memory drops the access
        cyc(); if_req = 1'b1; if_addr = 32'h700;
        mid(); grant_step(w);
        cyc(); if_req = 1'b0;
        mid(); check1("rw_issue_en", mem_en, 1'b1);
        cyc(); mid();
        cyc(); reset = 1'b1;
        mid(); check1("rw_busy_wait", busy, 1'b1);
        cyc(); reset = 1'b0;
        mid();
        check1("rw_busy_idle", busy, 1'b0);
        check1("rw_no_rvalid", if_rvalid | d_rvalid, 1'b0);
        check32("rw_if_rdata", if_rdata, 32'h0);
        void'(exp_q.pop_back());
        last_d = 1'b0; exp_d_rdata = 32'h0; exp_if_rdata = 32'h0;
        for (int i = 0; i < int'(LAT) + 2; i++) begin
            cyc(); mid();
            check1("rw_quiet", if_rvalid | d_rvalid | busy, 1'b0);
        end

        // First tie after reset goes to data in either mode
        cyc(); d_req = 1'b1; d_addr = 32'h800; if_req = 1'b1; if_addr = 32'h900;
        mid(); check1("tie_after_rst_d", d_gnt, 1'b1); grant_step(w);
        do_txn(w, 1'b0, 32'h900);
        cyc(); mid(); resp_step(w); grant_step(w2);
        do_txn(w2, 1'b0, 32'h0);
        cyc(); mid(); resp_step(w2);
        cyc(); mid();
        check32("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
